// File: rtl/cnt_ud_param.sv
// Parametrised synchronous up/down counter with programmable modulus, parallel load,
// wrap/saturate at the range ends, a combinational terminal count and a registered ovf event.
module cnt_ud_param #(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 2**WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             res,
    input  logic             t,
    input  logic             M,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    // One bit wider so MODULUS == 2**WIDTH is representable and the clamp never fires.
    localparam logic [WIDTH:0]   MODV = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             at_end;

    assign at_end = M ? (q_q == '0) : (q_q == MAXV);
    assign tc     = t & at_end;

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        if (ld) begin
            q_d = ({1'b0, ld_val} >= MODV) ? MAXV : ld_val;
        end else if (t) begin
            if (at_end) begin
                ovf_d = 1'b1;
                if (!SATURATE) q_d = M ? MAXV : '0;
            end else begin
                q_d = M ? (q_q - 1'b1) : (q_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign qb  = ~q_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_cnt_ud_param.sv
// Bench for cnt_ud_param: three configurations share one stimulus stream and are
// checked every cycle against a modular-arithmetic reference model.
module tb_cnt_ud_param;

    logic       clk = 1'b0;
    logic       res, t, M, ld;
    logic [3:0] lv;
    logic [2:0] q0, qb0, q1, qb1;
    logic [3:0] q2, qb2;
    logic       tc0, tc1, tc2, ovf0, ovf1, ovf2;

    always #5 clk = ~clk;

    cnt_ud_param #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) d0 (
        .clk(clk), .res(res), .t(t), .M(M), .ld(ld), .ld_val(lv[2:0]),
        .q(q0), .qb(qb0), .tc(tc0), .ovf(ovf0));
    cnt_ud_param #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b0)) d1 (
        .clk(clk), .res(res), .t(t), .M(M), .ld(ld), .ld_val(lv[2:0]),
        .q(q1), .qb(qb1), .tc(tc1), .ovf(ovf1));
    cnt_ud_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) d2 (
        .clk(clk), .res(res), .t(t), .M(M), .ld(ld), .ld_val(lv),
        .q(q2), .qb(qb2), .tc(tc2), .ovf(ovf2));

    int n_cmp = 0;
    int n_bad = 0;

    int mod_c[3] = '{8, 6, 10};
    int sat_c[3] = '{0, 0, 1};
    int msk_c[3] = '{7, 7, 15};
    int mq[3];
    int movf[3];
    bit mvalid = 1'b0;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    function automatic int get_q(input int i);
        case (i)
            0:       return int'(q0);
            1:       return int'(q1);
            default: return int'(q2);
        endcase
    endfunction

    function automatic int get_qb(input int i);
        case (i)
            0:       return int'(qb0);
            1:       return int'(qb1);
            default: return int'(qb2);
        endcase
    endfunction

    function automatic int get_tc(input int i);
        case (i)
            0:       return int'(tc0);
            1:       return int'(tc1);
            default: return int'(tc2);
        endcase
    endfunction

    function automatic int get_ovf(input int i);
        case (i)
            0:       return int'(ovf0);
            1:       return int'(ovf1);
            default: return int'(ovf2);
        endcase
    endfunction

    // One clock: drive at negedge, check tc before the edge, update model, check state after.
    task automatic cyc(input bit r, input bit tt, input bit mm, input bit l, input int v);
        int ends, val;
        @(negedge clk);
        res = r; t = tt; M = mm; ld = l; lv = 4'(v);
        #1;
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                ends = mm ? (mq[i] == 0) : (mq[i] == mod_c[i] - 1);
                chk($sformatf("tc[%0d]", i), get_tc(i), int'(tt) & ends);
            end
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            ends = mm ? (mq[i] == 0) : (mq[i] == mod_c[i] - 1);
            if (r) begin
                mq[i] = 0; movf[i] = 0;
            end else if (!mvalid) begin
                continue;
            end else if (l) begin
                val = v & msk_c[i];
                mq[i] = (val >= mod_c[i]) ? mod_c[i] - 1 : val;
                movf[i] = 0;
            end else if (tt) begin
                movf[i] = ends;
                if (!(ends && sat_c[i] != 0))
                    mq[i] = mm ? (mq[i] + mod_c[i] - 1) % mod_c[i] : (mq[i] + 1) % mod_c[i];
            end else begin
                movf[i] = 0;
            end
        end
        if (r) mvalid = 1'b1;
        #1;
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("q[%0d]", i), get_q(i), mq[i]);
                chk($sformatf("qb[%0d]", i), get_qb(i), (~mq[i]) & msk_c[i]);
                chk($sformatf("ovf[%0d]", i), get_ovf(i), movf[i]);
            end
        end
    endtask

    initial begin
        res = 1'b0; t = 1'b0; M = 1'b0; ld = 1'b0; lv = '0;
        cyc(1, 1, 0, 1, 5);
        chk("reset_q0", int'(q0), 0);
        chk("reset_qb2", int'(qb2), 15);
        // Up count through a full wrap.
        for (int k = 0; k < 9; k++) cyc(0, 1, 0, 0, 0);
        chk("wrap_q0", int'(q0), 1);
        // Down from zero: wrap to MODULUS-1.
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) cyc(0, 1, 1, 0, 0);
        // Saturate at top, then reverse.
        cyc(0, 0, 0, 1, 9);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0);
        chk("sat_ovf2", int'(ovf2), 1);
        cyc(0, 1, 1, 0, 0);
        chk("sat_rev_q2", int'(q2), 8);
        // Loads, clamp, and reset over load.
        cyc(0, 1, 0, 1, 7);
        chk("ld7_q2", int'(q2), 7);
        cyc(0, 1, 1, 1, 12);
        chk("clamp_q2", int'(q2), 9);
        cyc(1, 1, 0, 1, 12);
        chk("res_over_ld", int'(q2), 0);
        // Reset mid-count.
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0);
        // Direction toggle then hold.
        cyc(0, 1, 1, 0, 0);
        chk("toggle_q0", int'(q0), 2);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0);
        // Randomized traffic.
        for (int k = 0; k < 2000; k++)
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                int'($urandom_range(0, 15)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
